// File: rtl/issue_scoreboard.sv
// Issue scoreboard: tracks in-flight register writes and decides issue/stall
// for the decode instruction against ALU/MUL/DIV/LSU pipes.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   id_*               decode instruction (sources, dest, target pipe, serialize)
//   ix_ready           per-pipe accept
//   wb_do_branch       redirect; squashes the decode instruction this cycle
//   cmp_valid, cmp_rd  per-pipe completion pulse and its destination
//   issue_fire         instruction accepted this cycle
//   issue_stall        valid instruction held back (not by redirect)
//   sb_empty           nothing in flight
//   stall_cause        {serialize, structural, data}, one-hot while stalling
module issue_scoreboard #(
    parameter int NUM_PIPES = 4,
    parameter int CNT_WIDTH = 2,
    parameter int OUT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [4:0]             id_a1,
    input  logic [4:0]             id_a2,
    input  logic [4:0]             id_rd,
    input  logic                   id_register_write,
    input  logic [NUM_PIPES-1:0]   id_exe_pipe,
    input  logic                   id_serialize,
    input  logic [NUM_PIPES-1:0]   ix_ready,
    input  logic                   wb_do_branch,
    input  logic [NUM_PIPES-1:0]   cmp_valid,
    input  logic [NUM_PIPES*5-1:0] cmp_rd,
    output logic                   issue_fire,
    output logic                   issue_stall,
    output logic                   sb_empty,
    output logic [2:0]             stall_cause
);

    localparam int PW = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [OUT_WIDTH-1:0] OUT_MAX = '1;

    logic [CNT_WIDTH-1:0] pend_q  [32];
    logic [CNT_WIDTH-1:0] pend_d  [32];
    logic [PW-1:0]        owner_q [32];
    logic [PW-1:0]        owner_d [32];
    logic [OUT_WIDTH-1:0] out_q;
    logic [OUT_WIDTH-1:0] out_d;

    logic [PW-1:0] pipe_idx;
    logic          pipe_any;
    logic          data_raw;
    logic          data_waw;
    logic          rd_busy;
    logic          structural;
    logic          serialize;
    logic          out_full;
    logic          wr_fire;
    logic          underflow;

    always_comb begin
        pipe_idx = '0;
        for (int p = 0; p < NUM_PIPES; p++) begin
            if (id_exe_pipe[p]) pipe_idx = PW'(p);
        end
    end

    assign pipe_any = |id_exe_pipe;

    // Hazards look only at registered state; same-cycle completions
    // are not forwarded.
    assign data_raw = (id_a1 != 5'd0 && pend_q[id_a1] != '0) ||
                      (id_a2 != 5'd0 && pend_q[id_a2] != '0);

    assign rd_busy = id_rd != 5'd0 && pend_q[id_rd] != '0;

    // A second write from the owning pipe is safe (in-order completion)
    // unless the counter has no room left.
    assign data_waw = id_register_write && rd_busy &&
                      (owner_q[id_rd] != pipe_idx || pend_q[id_rd] == CNT_MAX);

    assign structural = pipe_any && !(|(id_exe_pipe & ix_ready));
    assign serialize  = id_serialize && out_q != '0;
    assign out_full   = out_q == OUT_MAX;

    assign issue_fire = id_valid && !wb_do_branch && !data_raw &&
                        !data_waw && !structural && !serialize && !out_full;

    assign issue_stall = id_valid && !issue_fire && !wb_do_branch;
    assign sb_empty    = out_q == '0;

    always_comb begin
        stall_cause = 3'b000;
        if (issue_stall) begin
            if (serialize)                    stall_cause = 3'b100;
            else if (structural || out_full)  stall_cause = 3'b010;
            else                              stall_cause = 3'b001;
        end
    end

    // NOPs (no target pipe) never touch state.
    assign wr_fire = issue_fire && pipe_any && id_register_write &&
                     id_rd != 5'd0;

    always_comb begin
        int net;
        int ncmp;
        underflow = 1'b0;
        ncmp = 0;
        for (int p = 0; p < NUM_PIPES; p++) begin
            if (cmp_valid[p]) ncmp = ncmp + 1;
        end
        net = int'(out_q) - ncmp;
        if (issue_fire && pipe_any) net = net + 1;
        if (net < 0) begin
            out_d = '0;
            underflow = 1'b1;
        end else begin
            out_d = OUT_WIDTH'(net);
        end
        for (int r = 0; r < 32; r++) begin
            net = int'(pend_q[r]);
            owner_d[r] = owner_q[r];
            if (wr_fire && id_rd == 5'(r)) begin
                net = net + 1;
                owner_d[r] = pipe_idx;
            end
            for (int p = 0; p < NUM_PIPES; p++) begin
                if (cmp_valid[p] && cmp_rd[p*5 +: 5] == 5'(r)) net = net - 1;
            end
            // Underflow holds at zero; also absorbs stale post-reset completions.
            if (r == 0) begin
                pend_d[r] = '0;
            end else if (net < 0) begin
                pend_d[r] = '0;
                underflow = 1'b1;
            end else begin
                pend_d[r] = CNT_WIDTH'(net);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            for (int r = 0; r < 32; r++) begin
                pend_q[r]  <= '0;
                owner_q[r] <= '0;
            end
        end else begin
            assert (!underflow);
            out_q <= out_d;
            for (int r = 0; r < 32; r++) begin
                pend_q[r]  <= pend_d[r];
                owner_q[r] <= owner_d[r];
            end
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed scenarios then random traffic,
// checked against a queue-based model of in-flight instructions.
module tb_issue_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_a1;
    logic [4:0]  id_a2;
    logic [4:0]  id_rd;
    logic        id_register_write;
    logic [3:0]  id_exe_pipe;
    logic        id_serialize;
    logic [3:0]  ix_ready;
    logic        wb_do_branch;
    logic [3:0]  cmp_valid;
    logic [19:0] cmp_rd;
    logic        issue_fire;
    logic        issue_stall;
    logic        sb_empty;
    logic [2:0]  stall_cause;

    always #5 clk = ~clk;

    issue_scoreboard dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_a1(id_a1), .id_a2(id_a2), .id_rd(id_rd),
        .id_register_write(id_register_write), .id_exe_pipe(id_exe_pipe),
        .id_serialize(id_serialize), .ix_ready(ix_ready),
        .wb_do_branch(wb_do_branch), .cmp_valid(cmp_valid), .cmp_rd(cmp_rd),
        .issue_fire(issue_fire), .issue_stall(issue_stall),
        .sb_empty(sb_empty), .stall_cause(stall_cause)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: per-pipe queues of destinations of in-flight instructions.
    int q[4][$];
    int last_own[32];

    logic       last_fire;
    logic       last_stall;
    logic       last_empty;
    logic [2:0] last_cause;

    function automatic int pend(int r);
        int n = 0;
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < q[p].size(); i++)
                if (q[p][i] == r) n++;
        return n;
    endfunction

    function automatic int total();
        int n = 0;
        for (int p = 0; p < 4; p++) n += q[p].size();
        return n;
    endfunction

    task automatic chk(input string tag, input logic [2:0] obs,
                       input logic [2:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0;
        id_valid = 1'b0;
        id_a1 = '0;
        id_a2 = '0;
        id_rd = '0;
        id_register_write = 1'b0;
        id_exe_pipe = '0;
        id_serialize = 1'b0;
        ix_ready = 4'hF;
        wb_do_branch = 1'b0;
        cmp_valid = '0;
        cmp_rd = '0;
    endtask

    task automatic ins(input logic [3:0] pipe, input int rd, input int a1,
                       input int a2, input logic ser);
        id_valid = 1'b1;
        id_exe_pipe = pipe;
        id_rd = 5'(rd);
        id_register_write = rd != 0;
        id_a1 = 5'(a1);
        id_a2 = 5'(a2);
        id_serialize = ser;
    endtask

    task automatic comp(input int p);
        cmp_valid[p] = 1'b1;
        cmp_rd[p*5 +: 5] = 5'(q[p][0]);
    endtask

    // Called at a negedge with inputs driven; checks, then advances a cycle.
    task automatic cycle();
        int e_pipe;
        int prd;
        bit raw, waw, st, ser, full, fire, stall;
        logic [2:0] cause;
        e_pipe = -1;
        for (int p = 0; p < 4; p++) if (id_exe_pipe[p]) e_pipe = p;
        prd = pend(int'(id_rd));
        raw = (id_a1 != 0 && pend(int'(id_a1)) > 0) ||
              (id_a2 != 0 && pend(int'(id_a2)) > 0);
        waw = id_register_write && id_rd != 0 && prd > 0 &&
              (last_own[id_rd] != e_pipe || prd == 3);
        st = id_exe_pipe != 0 && (id_exe_pipe & ix_ready) == 0;
        full = total() == 15;
        ser = id_serialize && total() != 0;
        fire = id_valid && !wb_do_branch && !raw && !waw && !st && !ser && !full;
        stall = id_valid && !fire && !wb_do_branch;
        cause = !stall ? 3'b000 : ser ? 3'b100 : (st || full) ? 3'b010 : 3'b001;
        #1;
        last_fire = issue_fire;
        last_stall = issue_stall;
        last_empty = sb_empty;
        last_cause = stall_cause;
        chk("fire", {2'b0, issue_fire}, {2'b0, fire});
        chk("stall", {2'b0, issue_stall}, {2'b0, stall});
        chk("empty", {2'b0, sb_empty}, {2'b0, total() == 0});
        chk("cause", stall_cause, cause);
        @(posedge clk);
        if (rst) begin
            for (int p = 0; p < 4; p++) q[p].delete();
            for (int r = 0; r < 32; r++) last_own[r] = 0;
        end else begin
            for (int p = 0; p < 4; p++) if (cmp_valid[p]) void'(q[p].pop_front());
            if (fire && e_pipe >= 0) begin
                q[e_pipe].push_back(id_register_write ? int'(id_rd) : 0);
                if (id_register_write) last_own[id_rd] = e_pipe;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) last_own[r] = 0;
        idle();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        cycle();
        chk("rst_empty", {2'b0, last_empty}, 3'b001);
        chk("rst_fire", {2'b0, last_fire}, 3'b000);
        chk("rst_cause", last_cause, 3'b000);

        // ALU add x5
        ins(4'b0001, 5, 1, 2, 0); cycle();
        chk("t1_fire", {2'b0, last_fire}, 3'b001);
        idle(); cycle();
        chk("t1_busy", {2'b0, last_empty}, 3'b000);
        comp(0); cycle();
        idle(); cycle();
        chk("t1_drained", {2'b0, last_empty}, 3'b001);

        // RAW on a pending load
        ins(4'b1000, 5, 0, 0, 0); cycle();
        chk("t2_ld", {2'b0, last_fire}, 3'b001);
        ins(4'b0001, 6, 5, 1, 0); cycle();
        chk("t2_stall", {2'b0, last_stall}, 3'b001);
        chk("t2_cause", last_cause, 3'b001);
        cycle();
        comp(3); cycle();
        chk("t2_nofwd", last_cause, 3'b001);
        cmp_valid = '0; cycle();
        chk("t2_fire", {2'b0, last_fire}, 3'b001);
        idle(); comp(0); cycle();

        // Same-pipe WAW allowed, cross-pipe WAW stalls
        idle(); ins(4'b0010, 7, 0, 0, 0); cycle();
        chk("t3_mul0", {2'b0, last_fire}, 3'b001);
        cycle();
        chk("t3_mul1", {2'b0, last_fire}, 3'b001);
        ins(4'b0100, 7, 0, 0, 0); cycle();
        chk("t3_waw", last_cause, 3'b001);
        comp(1); cycle();
        cmp_valid = '0; comp(1); cycle();
        chk("t3_waw2", last_cause, 3'b001);
        cmp_valid = '0; cycle();
        chk("t3_div", {2'b0, last_fire}, 3'b001);
        idle(); comp(2); cycle();

        // Counter saturation: fourth same-pipe write stalls
        idle(); ins(4'b0010, 8, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("sat_fire", {2'b0, last_fire}, 3'b001);
        end
        cycle();
        chk("sat_stall", last_cause, 3'b001);
        for (int i = 0; i < 3; i++) begin idle(); comp(1); cycle(); end

        // Serialize drains three in-flight ops
        idle();
        for (int i = 0; i < 3; i++) begin ins(4'b0001, 10 + i, 0, 0, 0); cycle(); end
        ins(4'b1000, 0, 0, 0, 1); cycle();
        chk("t4_ser", last_cause, 3'b100);
        for (int i = 0; i < 3; i++) begin
            cmp_valid = '0; comp(0); cycle();
            chk("t4_ser_hold", last_cause, 3'b100);
        end
        cmp_valid = '0; cycle();
        chk("t4_fire", {2'b0, last_fire}, 3'b001);
        idle(); comp(3); cycle();

        // Structural stall, then redirect in the same situation
        idle(); ix_ready = 4'b1011; ins(4'b0100, 13, 0, 0, 0); cycle();
        chk("t5_struct", last_cause, 3'b010);
        wb_do_branch = 1'b1; cycle();
        chk("t5_br_fire", {2'b0, last_fire}, 3'b000);
        chk("t5_br_stall", {2'b0, last_stall}, 3'b000);
        chk("t5_br_cause", last_cause, 3'b000);
        idle(); cycle();
        chk("t5_nochange", {2'b0, last_empty}, 3'b001);

        // Issue and completion to x9 in one cycle keep the net count
        ins(4'b0001, 9, 0, 0, 0); cycle();
        comp(0); cycle();
        chk("t6_fire", {2'b0, last_fire}, 3'b001);
        idle(); ins(4'b0001, 0, 9, 0, 0); cycle();
        chk("t6_still", last_cause, 3'b001);
        chk("t6_busy", {2'b0, last_empty}, 3'b000);
        comp(0); cycle();
        cmp_valid = '0; cycle();
        chk("t6_read", {2'b0, last_fire}, 3'b001);
        idle(); comp(0); cycle();
        idle(); cycle();
        chk("t6_drained", {2'b0, last_empty}, 3'b001);

        // In-flight counter full
        for (int i = 0; i < 15; i++) begin ins(4'b0001, 0, 0, 0, 0); cycle(); end
        cycle();
        chk("full_cause", last_cause, 3'b010);
        for (int i = 0; i < 15; i++) begin idle(); comp(0); cycle(); end
        idle(); cycle();
        chk("full_drained", {2'b0, last_empty}, 3'b001);

        // Invalid instruction fires as a NOP
        ins(4'b0000, 0, 0, 0, 0); cycle();
        chk("nop_fire", {2'b0, last_fire}, 3'b001);
        idle(); cycle();
        chk("nop_empty", {2'b0, last_empty}, 3'b001);

        // Reset mid-operation
        ins(4'b0001, 20, 0, 0, 0); cycle();
        ins(4'b0010, 21, 0, 0, 0); cycle();
        idle(); rst = 1'b1; cycle();
        rst = 1'b0; cycle();
        chk("mrst_empty", {2'b0, last_empty}, 3'b001);
        ins(4'b0001, 0, 20, 21, 0); cycle();
        chk("mrst_fire", {2'b0, last_fire}, 3'b001);
        idle(); comp(0); cycle();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            int p;
            int rd;
            idle();
            id_valid = ($urandom % 4) != 0;
            p = int'($urandom % 5);
            id_exe_pipe = (p == 4) ? 4'b0000 : 4'(1 << p);
            rd = int'($urandom % 8);
            id_rd = 5'(rd);
            id_register_write = id_exe_pipe != 0 && rd != 0 && ($urandom % 4) != 0;
            id_a1 = 5'($urandom % 8);
            id_a2 = 5'($urandom % 8);
            id_serialize = id_exe_pipe != 0 && ($urandom % 16) == 0;
            ix_ready = (($urandom % 4) == 0) ? 4'($urandom) : 4'hF;
            wb_do_branch = ($urandom % 12) == 0;
            for (int k = 0; k < 4; k++)
                if (q[k].size() > 0 && ($urandom % 3) == 0) comp(k);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
